// File: rtl/ir_key_event.sv
// NEC remote key event generator: press / repeat / release / held.
// Optional IR_EXT_ADDR_EN: extended addressing, address complement not checked.
module ir_key_event #(
  parameter int HOLD_CYC = 6_000_000,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ir_dout,
  input  logic             ir_dout_vld,
  input  logic             ir_rpt,
  output logic [7:0]       key_code,
  output logic [15:0]      key_addr,
  output logic             key_press,
  output logic             key_rpt,
  output logic             key_release,
  output logic             key_held,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int TW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    SWAP
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [7:0]      pend_code, pend_code_n;
  logic [15:0]     pend_addr, pend_addr_n;
  logic [7:0]      code_n;
  logic [15:0]     addr_n;
  logic            press_n, rpt_n, rel_n, held_n;
  logic [ERR_W-1:0] err_n;

  logic            cmd_ok, frm_ok, frm_new, frm_bad;
  logic            same, refresh;
  logic [15:0]     frm_addr;

  // Frame qualification and match against the currently held key
  always_comb begin
    cmd_ok = (ir_dout[23:16] == ~ir_dout[31:24]);
`ifdef IR_EXT_ADDR_EN
    frm_ok   = cmd_ok;
    frm_addr = ir_dout[15:0];
`else
    frm_ok   = cmd_ok && (ir_dout[7:0] == ~ir_dout[15:8]);
    frm_addr = {8'h00, ir_dout[7:0]};
`endif
    frm_new = ir_dout_vld && frm_ok;
    frm_bad = ir_dout_vld && !frm_ok;
    same    = frm_new && (ir_dout[23:16] == key_code)
              && (frm_addr == key_addr);
    // a frame in the same cycle masks a repeat strobe
    refresh = same || (!ir_dout_vld && ir_rpt);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    pend_code_n = pend_code;
    pend_addr_n = pend_addr;
    code_n      = key_code;
    addr_n      = key_addr;
    press_n     = 1'b0;
    rpt_n       = 1'b0;
    rel_n       = 1'b0;
    held_n      = key_held;
    err_n       = err_cnt;
    if (frm_bad && (err_cnt != {ERR_W{1'b1}}))
      err_n = err_cnt + ERR_W'(1);
    case (state)
      IDLE: begin
        if (frm_new) begin
          code_n  = ir_dout[23:16];
          addr_n  = frm_addr;
          press_n = 1'b1;
          held_n  = 1'b1;
          timer_n = RELOAD;
          state_n = HELD;
        end
      end
      HELD: begin
        if (frm_new && !same) begin
          rel_n       = 1'b1;
          pend_code_n = ir_dout[23:16];
          pend_addr_n = frm_addr;
          state_n     = SWAP;
        end else if (refresh) begin
          rpt_n   = 1'b1;
          timer_n = RELOAD;
        end else if (timer == '0) begin
          rel_n   = 1'b1;
          held_n  = 1'b0;
          state_n = IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      SWAP: begin
        code_n  = pend_code;
        addr_n  = pend_addr;
        press_n = 1'b1;
        timer_n = RELOAD;
        state_n = HELD;
      end
      default: begin
        state_n = IDLE;
        held_n  = 1'b0;
      end
    endcase
  end

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      pend_code   <= '0;
      pend_addr   <= '0;
      key_code    <= '0;
      key_addr    <= '0;
      key_press   <= 1'b0;
      key_rpt     <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      pend_code   <= pend_code_n;
      pend_addr   <= pend_addr_n;
      key_code    <= code_n;
      key_addr    <= addr_n;
      key_press   <= press_n;
      key_rpt     <= rpt_n;
      key_release <= rel_n;
      key_held    <= held_n;
      err_cnt     <= err_n;
    end
  end

endmodule

// File: tb/tb_ir_key_event.sv
// Bench for ir_key_event: deadline-based reference model,
// per-cycle expectation queue drained by an independent monitor.
module tb_ir_key_event;

  localparam int HOLD    = 100;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir_dout = '0;
  logic        ir_dout_vld = 1'b0;
  logic        ir_rpt = 1'b0;
  logic [7:0]  key_code;
  logic [15:0] key_addr;
  logic        key_press, key_rpt, key_release, key_held;
  logic [ERR_W-1:0] err_cnt;

  ir_key_event #(.HOLD_CYC(HOLD), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ir_dout(ir_dout), .ir_dout_vld(ir_dout_vld), .ir_rpt(ir_rpt),
    .key_code(key_code), .key_addr(key_addr),
    .key_press(key_press), .key_rpt(key_rpt),
    .key_release(key_release), .key_held(key_held),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  code;
    logic [15:0] addr;
    logic        press;
    logic        rpt;
    logic        rel;
    logic        held;
    logic [7:0]  err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: a key is held until the cycle count reaches
  // the deadline set by the last press or refresh
  longint cyc = 0;
  longint deadline = 0;
  bit     m_held = 0, m_swap = 0;
  int     m_code = 0, m_addr = 0, p_code = 0, p_addr = 0, m_err = 0;

  function automatic bit frame_ok(input logic [31:0] d);
    bit c;
    c = ((d[23:16] ^ d[31:24]) == 8'hFF);
`ifdef IR_EXT_ADDR_EN
    return c;
`else
    return c && ((d[7:0] ^ d[15:8]) == 8'hFF);
`endif
  endfunction

  function automatic int frame_addr(input logic [31:0] d);
`ifdef IR_EXT_ADDR_EN
    return int'(d[15:0]);
`else
    return int'(d[7:0]);
`endif
  endfunction

  task automatic model(input bit rst, input bit vld,
                       input logic [31:0] d, input bit rpt);
    obs_t e;
    bit ok, same, press, rp, rel;
    cyc++;
    press = 0; rp = 0; rel = 0;
    if (rst) begin
      m_held = 0; m_swap = 0; m_code = 0; m_addr = 0; m_err = 0;
    end else begin
      ok = vld && frame_ok(d);
      if (vld && !ok && m_err < ERR_MAX) m_err++;
      if (m_swap) begin
        m_code = p_code; m_addr = p_addr;
        press = 1; m_swap = 0; deadline = cyc + HOLD;
      end else if (m_held) begin
        same = ok && (int'(d[23:16]) == m_code)
               && (frame_addr(d) == m_addr);
        if (ok && !same) begin
          rel = 1; m_swap = 1;
          p_code = int'(d[23:16]); p_addr = frame_addr(d);
        end else if (same || (!vld && rpt)) begin
          rp = 1; deadline = cyc + HOLD;
        end else if (cyc >= deadline) begin
          rel = 1; m_held = 0;
        end
      end else if (ok) begin
        m_code = int'(d[23:16]); m_addr = frame_addr(d);
        press = 1; m_held = 1; deadline = cyc + HOLD;
      end
    end
    e.code  = m_code[7:0];
    e.addr  = m_addr[15:0];
    e.press = press;
    e.rpt   = rp;
    e.rel   = rel;
    e.held  = m_held;
    e.err   = m_err[7:0];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit vld, input logic [31:0] d, input bit rpt);
    @(negedge clk);
    rst_n = 1'b1;
    ir_dout_vld = vld;
    ir_dout = d;
    ir_rpt = rpt;
    model(1'b0, vld, d, rpt);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    ir_dout_vld = 1'b0;
    ir_rpt = 1'b0;
    model(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] mk_frame(input logic [7:0] a,
                                           input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // monitor: one expectation per clock, compared after the edge
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {key_code, key_addr, key_press, key_rpt,
           key_release, key_held, err_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got code=%h addr=%h p=%b r=%b rel=%b h=%b err=%0d exp code=%h addr=%h p=%b r=%b rel=%b h=%b err=%0d",
          $time, a.code, a.addr, a.press, a.rpt, a.rel, a.held, a.err,
          e.code, e.addr, e.press, e.rpt, e.rel, e.held, e.err);
      end
      checks++;
      if ($countones({key_press, key_rpt, key_release}) > 1) begin
        errors++;
        $display("FAIL pulse_excl t=%0t got %b%b%b exp at most one",
          $time, key_press, key_rpt, key_release);
      end
    end
  end

  initial begin
    int r;
    reset_cycle();
    reset_cycle();
    // press, timeout release
    step(1, 32'hBA45FF00, 0);
    idle(110);
    // five repeats 80 cycles apart, then timeout
    step(1, 32'hBA45FF00, 0);
    for (int i = 0; i < 5; i++) begin
      idle(79);
      step(0, $urandom, 1);
    end
    idle(110);
    // key change
    step(1, 32'hBA45FF00, 0);
    idle(10);
    step(1, 32'hBF40FF00, 0);
    idle(3);
    step(1, 32'hBF40FF00, 0);
    idle(110);
    // invalid frames and saturation
    step(1, 32'hBA46FF00, 0);
    idle(2);
    for (int i = 0; i < 300; i++) step(1, 32'hBA46FF00, 0);
    idle(2);
    reset_cycle();
    // extended-address frame
    step(1, 32'hBA453412, 0);
    idle(110);
    // frame with simultaneous repeat, reset mid-hold
    step(1, 32'hBA45FF00, 1);
    idle(5);
    step(1, 32'hBA46FF00, 1);
    idle(3);
    reset_cycle();
    idle(3);
    step(1, 32'hBA45FF00, 0);
    // refresh exactly at the deadline, then expiry, then ignored repeat
    idle(99);
    step(0, 32'h0, 1);
    idle(99);
    step(1, 32'hBA45FF00, 0);
    idle(100);
    step(0, 32'h0, 1);
    idle(5);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0) idle(130);
      else if (r < 8) step(1, mk_frame(8'h00, 8'h45), $urandom_range(0, 1));
      else if (r < 12) step(1, mk_frame(8'h00, 8'h40), 0);
      else if (r < 15) step(1, mk_frame($urandom, $urandom), 0);
      else if (r < 17) step(1, 32'hBA453412, 0);
      else if (r < 19) step(1, $urandom, $urandom_range(0, 1));
      else if (r < 28) step(0, $urandom, 1);
      else if (r == 28) reset_cycle();
      else step(0, $urandom, 0);
    end
    idle(2);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_key_event.md
IR_KEY_EVENT -- requirements
Module: ir_key_event

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 6_000_000, hold timeout in clk cycles (120 ms at 50 MHz).
REQ-002 SHALL have parameter ERR_W, default 8, width of the rejected-frame counter.
REQ-003 SHALL have port clk  in  1  system clock (CLOCK_50 domain).
REQ-004 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous, active-low.
REQ-005 SHALL have port ir_dout  in  32  decoded NEC frame: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
REQ-006 SHALL have port ir_dout_vld  in  1  one-cycle strobe, ir_dout valid.
REQ-007 SHALL have port ir_rpt  in  1  one-cycle NEC repeat-code strobe; tie 0 if the decoder lacks it.
REQ-008 SHALL have port key_code  out  8  command byte of the current or last key.
REQ-009 SHALL have port key_addr  out  16  address of the current or last key.
REQ-010 SHALL have port key_press  out  1  one-cycle pulse, new key down.
REQ-011 SHALL have port key_rpt  out  1  one-cycle pulse, held key refreshed.
REQ-012 SHALL have port key_release  out  1  one-cycle pulse, key up.
REQ-013 SHALL have port key_held  out  1  level, high while a key is held.
REQ-014 SHALL have port err_cnt  out  ERR_W  saturating count of rejected frames.

Function
REQ-015 SHALL sample the inputs on every rising clk; all outputs SHALL be registered, and every pulse SHALL appear the cycle after the triggering strobe.
REQ-016 SHALL deem a frame valid when cmd == ~cmd byte and addr == ~addr byte; otherwise invalid.
REQ-017 SHALL increment err_cnt by 1 on each invalid frame, saturating at all-ones, in every state.
REQ-018 SHALL implement FSM states IDLE, HELD, SWAP.
REQ-019 IDLE + valid frame: latch key_code/key_addr, pulse key_press, set key_held, load timer with HOLD_CYC-1, go HELD.
REQ-020 IDLE + ir_rpt: ignored, no output change.
REQ-021 HELD + ir_rpt: reload timer, pulse key_rpt.
REQ-022 HELD + valid frame with same code and address: treat as repeat (reload timer, pulse key_rpt).
REQ-023 HELD + valid frame with different code or address: pulse key_release with the old key_code, hold the new frame internally, go SWAP.
REQ-024 SWAP: the next cycle SHALL latch the new key, pulse key_press, reload the timer and go HELD; ir_dout_vld/ir_rpt during SWAP are ignored (err_cnt still counts).
REQ-025 HELD + invalid frame: no timer reload, no state change.
REQ-026 HELD: the timer decrements each cycle; at 0 with no refresh in that cycle, pulse key_release, clear key_held, go IDLE.
REQ-027 A refresh in the same cycle the timer reaches 0 SHALL win (reload, stay HELD).
REQ-028 Simultaneous ir_dout_vld and ir_rpt: the frame SHALL take priority and ir_rpt is ignored.
REQ-029 key_press, key_rpt and key_release SHALL never be high in the same cycle.
REQ-030 key_code/key_addr SHALL hold their value after release until the next press.
REQ-031 Standard mode: key_addr = {8'h00, addr}.

Reset
REQ-032 On rst_n low, SHALL asynchronously enter IDLE with key_code=0, key_addr=0, all pulses 0, key_held=0, err_cnt=0, timer=0.
REQ-033 A reset mid-hold SHALL emit no key_release; after release of reset, the first valid frame SHALL produce key_press.

Configuration
REQ-034 Macro IR_EXT_ADDR_EN defined: NEC extended addressing; the address complement check is skipped, and key_addr = ir_dout[15:0].
REQ-035 Macro IR_EXT_ADDR_EN undefined: behaviour per REQ-016 and REQ-031.

Verification (HOLD_CYC=100)
REQ-036 Frame 32'hBA45FF00 from IDLE -> next cycle key_press=1, key_code=8'h45, key_addr=16'h0000, key_held=1; 100 cycles with no refresh -> single key_release, key_held=0.
REQ-037 Held 8'h45, ir_rpt every 80 cycles 5 times -> 5 key_rpt pulses, no release until 100 cycles after the last ir_rpt.
REQ-038 Held 8'h45, frame 32'hBF40FF00 -> key_release (key_code 8'h45), next cycle key_press (key_code 8'h40).
REQ-039 Frame 32'hBA46FF00 -> err_cnt 0->1, no pulses; 300 such frames -> err_cnt saturates at 255.
REQ-040 Frame 32'hBA453412 -> without IR_EXT_ADDR_EN: rejected, err_cnt+1; with IR_EXT_ADDR_EN: key_press, key_addr=16'h3412.
REQ-041 ir_dout_vld and ir_rpt asserted in the same cycle from IDLE with 32'hBA45FF00 -> key_press only, no key_rpt; rst_n pulse while held -> outputs zero, no key_release.
